// File: rtl/interlaken_pkg.sv
// Shared Interlaken constants: control-word encodings, 64B/67B headers and the
// metaframe sequencer state encoding.
package interlaken_pkg;

  localparam logic [63:0] SYNC_WORD = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] SKIP_WORD = 64'h1E1E_1E1E_1E1E_1E1E;
  localparam logic [5:0]  SCRAM_TAG = 6'b001010;
  localparam logic [5:0]  DIAG_TAG  = 6'b011001;
  localparam logic [1:0]  HDR_DATA  = 2'b01;
  localparam logic [1:0]  HDR_CTRL  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_SCRAM   = 3'd2,
    ST_SKIP    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_DIAG    = 3'd5
  } mf_state_e;

endpackage

// File: rtl/metaframe_sequencer.sv
// Interlaken metaframe sequencer: frames user payload with Sync, Scrambler
// State, Skip and Diagnostic control words ahead of the 64B/67B encoder.
module metaframe_sequencer
  import interlaken_pkg::*;
#(
  parameter int METAFRAME_LEN = 2048
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET_N,
  input  logic        ENABLE,
  input  logic [63:0] DATA_IN,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  input  logic [57:0] SCRAM_STATE,
  input  logic [1:0]  LANE_STATUS,
  input  logic [31:0] DIAG_CRC32,
  output logic [63:0] TX_DATA,
  output logic [1:0]  TX_HEADER,
  output logic        TX_PASSTHROUGH,
  output logic        METAFRAME_START
);

  // Last payload slot index; the payload region spans slots 0..LAST_SLOT.
  localparam logic [15:0] LAST_SLOT = 16'(METAFRAME_LEN - 5);

  mf_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] tx_data_q, tx_data_d;
  logic [1:0]  tx_header_q, tx_header_d;
  logic        tx_pt_q, tx_pt_d;
  logic        mf_start_q, mf_start_d;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_data_d   = SKIP_WORD;
    tx_header_d = HDR_CTRL;
    tx_pt_d     = 1'b0;
    mf_start_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_pt_d = 1'b1;
        if (ENABLE) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        tx_data_d  = SYNC_WORD;
        mf_start_d = 1'b1;
        state_d    = ST_SCRAM;
      end
      ST_SCRAM: begin
        tx_data_d = {SCRAM_TAG, SCRAM_STATE};
        state_d   = ST_SKIP;
      end
      ST_SKIP: begin
        cnt_d   = 16'd0;
        state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // An empty slot still costs a slot: a Skip word fills it.
        if (DATA_VALID) begin
          tx_data_d   = DATA_IN;
          tx_header_d = HDR_DATA;
        end
        if (cnt_q == LAST_SLOT) state_d = ST_DIAG;
        else                    cnt_d   = cnt_q + 16'd1;
      end
      ST_DIAG: begin
        tx_data_d = {DIAG_TAG, 24'h0, LANE_STATUS, DIAG_CRC32};
        state_d   = ENABLE ? ST_SYNC : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      tx_data_q   <= SKIP_WORD;
      tx_header_q <= HDR_CTRL;
      tx_pt_q     <= 1'b1;
      mf_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_header_q <= tx_header_d;
      tx_pt_q     <= tx_pt_d;
      mf_start_q  <= mf_start_d;
    end
  end

  assign DATA_READY      = (state_q == ST_PAYLOAD);
  assign TX_DATA         = tx_data_q;
  assign TX_HEADER       = tx_header_q;
  assign TX_PASSTHROUGH  = tx_pt_q;
  assign METAFRAME_START = mf_start_q;

endmodule

// File: tb/tb_metaframe_sequencer.sv
// Directed bench for metaframe_sequencer with METAFRAME_LEN = 8: expected
// words are hand-computed constants, payload words count up from 1.
module tb_metaframe_sequencer;

  localparam logic [63:0] SYNC_W  = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] SKIP_W  = 64'h1E1E_1E1E_1E1E_1E1E;
  localparam logic [63:0] SCRAM_W = 64'h2AAB_CDEF_0123_4567;
  localparam logic [63:0] DIAG_W  = 64'h6400_0003_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [57:0] scram_state;
  logic [1:0]  lane_status;
  logic [31:0] diag_crc32;
  logic [63:0] tx_data;
  logic [1:0]  tx_header;
  logic        tx_passthrough;
  logic        metaframe_start;

  int n_cmp = 0;
  int n_err = 0;

  metaframe_sequencer #(.METAFRAME_LEN(8)) dut (
    .USER_CLK        (clk),
    .SYSTEM_RESET_N  (rst_n),
    .ENABLE          (enable),
    .DATA_IN         (data_in),
    .DATA_VALID      (data_valid),
    .DATA_READY      (data_ready),
    .SCRAM_STATE     (scram_state),
    .LANE_STATUS     (lane_status),
    .DIAG_CRC32      (diag_crc32),
    .TX_DATA         (tx_data),
    .TX_HEADER       (tx_header),
    .TX_PASSTHROUGH  (tx_passthrough),
    .METAFRAME_START (metaframe_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [63:0] d, input logic [1:0] h,
                             input logic pt, input logic st);
    check({tag, ".data"},  tx_data, d);
    check({tag, ".hdr"},   64'(tx_header), 64'(h));
    check({tag, ".pt"},    64'(tx_passthrough), 64'(pt));
    check({tag, ".start"}, 64'(metaframe_start), 64'(st));
  endtask

  // One clock: a word offered while DATA_READY is high is consumed at the
  // edge, so the next payload value is presented afterwards.
  task automatic step();
    logic taken;
    taken = data_ready && data_valid;
    @(posedge clk);
    #1;
    if (taken) data_in = data_in + 64'd1;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    data_valid  = 1'b1;
    data_in     = 64'd1;
    scram_state = 58'h2AB_CDEF_0123_4567;
    lane_status = 2'b11;
    diag_crc32  = 32'hDEADBEEF;

    repeat (2) step();
    expect_word("reset", SKIP_W, 2'b10, 1'b1, 1'b0);
    check("reset.ready", 64'(data_ready), 64'd0);

    rst_n  = 1'b1;
    enable = 1'b1;

    // Back-to-back metaframes, every slot carrying valid data.
    step(); expect_word("mf1.idle",  SKIP_W,  2'b10, 1'b1, 1'b0);
    step(); expect_word("mf1.sync",  SYNC_W,  2'b10, 1'b0, 1'b1);
    step(); expect_word("mf1.scram", SCRAM_W, 2'b10, 1'b0, 1'b0);
    step(); expect_word("mf1.skip",  SKIP_W,  2'b10, 1'b0, 1'b0);
    check("mf1.ready_in_payload", 64'(data_ready), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      step(); expect_word($sformatf("mf1.d%0d", i), 64'(i), 2'b01, 1'b0, 1'b0);
    end
    check("mf1.ready_in_diag", 64'(data_ready), 64'd0);
    step(); expect_word("mf1.diag",  DIAG_W,  2'b10, 1'b0, 1'b0);
    step(); expect_word("mf2.sync",  SYNC_W,  2'b10, 1'b0, 1'b1);

    // Second payload slot empty: a Skip word takes it, Diag stays in slot 8.
    step(); expect_word("mf2.scram", SCRAM_W, 2'b10, 1'b0, 1'b0);
    step(); expect_word("mf2.skip",  SKIP_W,  2'b10, 1'b0, 1'b0);
    step(); expect_word("mf2.d5",    64'd5,   2'b01, 1'b0, 1'b0);
    data_valid = 1'b0;
    step(); expect_word("mf2.hole",  SKIP_W,  2'b10, 1'b0, 1'b0);
    data_valid = 1'b1;
    step(); expect_word("mf2.d6",    64'd6,   2'b01, 1'b0, 1'b0);
    step(); expect_word("mf2.d7",    64'd7,   2'b01, 1'b0, 1'b0);
    step(); expect_word("mf2.diag",  DIAG_W,  2'b10, 1'b0, 1'b0);

    // ENABLE drops in the first payload cycle: the metaframe still completes.
    step(); expect_word("mf3.sync",  SYNC_W,  2'b10, 1'b0, 1'b1);
    step(); expect_word("mf3.scram", SCRAM_W, 2'b10, 1'b0, 1'b0);
    step(); expect_word("mf3.skip",  SKIP_W,  2'b10, 1'b0, 1'b0);
    enable = 1'b0;
    for (int i = 8; i <= 11; i++) begin
      step(); expect_word($sformatf("mf3.d%0d", i), 64'(i), 2'b01, 1'b0, 1'b0);
    end
    step(); expect_word("mf3.diag",  DIAG_W,  2'b10, 1'b0, 1'b0);
    step(); expect_word("idle1",     SKIP_W,  2'b10, 1'b1, 1'b0);
    step(); expect_word("idle2",     SKIP_W,  2'b10, 1'b1, 1'b0);
    check("idle.ready", 64'(data_ready), 64'd0);

    // Reset mid-payload abandons the metaframe at once.
    enable = 1'b1;
    step(); expect_word("mf4.idle",  SKIP_W,  2'b10, 1'b1, 1'b0);
    step(); expect_word("mf4.sync",  SYNC_W,  2'b10, 1'b0, 1'b1);
    step(); expect_word("mf4.scram", SCRAM_W, 2'b10, 1'b0, 1'b0);
    step(); expect_word("mf4.skip",  SKIP_W,  2'b10, 1'b0, 1'b0);
    step(); expect_word("mf4.d12",   64'd12,  2'b01, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_word("rst_mid", SKIP_W, 2'b10, 1'b1, 1'b0);
    check("rst_mid.ready", 64'(data_ready), 64'd0);
    step(); expect_word("rst_hold",  SKIP_W,  2'b10, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(); expect_word("rel.1",     SKIP_W,  2'b10, 1'b1, 1'b0);
    step(); expect_word("rel.2sync", SYNC_W,  2'b10, 1'b0, 1'b1);
    step(); expect_word("rel.scram", SCRAM_W, 2'b10, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/metaframe_sequencer.md
METAFRAME_SEQUENCER -- requirements
Module: metaframe_sequencer

Interface
REQ-001 SHALL have parameter METAFRAME_LEN, default 2048: words per metaframe including the 4 control words; legal range 5..65535.
REQ-002 SHALL have USER_CLK  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have SYSTEM_RESET_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ENABLE  input  1  level; high requests metaframe generation.
REQ-005 SHALL have DATA_IN  input  64  payload word from the user side.
REQ-006 SHALL have DATA_VALID  input  1  DATA_IN is valid.
REQ-007 SHALL have DATA_READY  output  1  sequencer accepts DATA_IN this cycle.
REQ-008 SHALL have SCRAM_STATE  input  58  scrambler state, sampled for the Scrambler State word.
REQ-009 SHALL have LANE_STATUS  input  2  status bits, sampled for the Diagnostic word.
REQ-010 SHALL have DIAG_CRC32  input  32  CRC32 value, sampled for the Diagnostic word.
REQ-011 SHALL have TX_DATA  output  64  word to the 64B/67B encoder DATA_IN.
REQ-012 SHALL have TX_HEADER  output  2  header to the encoder HEADER_IN; 01 = data, 10 = control.
REQ-013 SHALL have TX_PASSTHROUGH  output  1  drives the encoder PASSTHROUGH.
REQ-014 SHALL have METAFRAME_START  output  1  one-cycle pulse coincident with each Sync word on TX_DATA.

Function
REQ-015 SHALL implement states IDLE, SYNC, SCRAM, SKIP, PAYLOAD, DIAG; each state emits exactly one word per cycle, except PAYLOAD, which lasts METAFRAME_LEN-4 cycles.
REQ-016 SHALL transition IDLE->SYNC on the first cycle with ENABLE high, then SYNC->SCRAM->SKIP->PAYLOAD->DIAG.
REQ-017 SHALL leave DIAG for SYNC if ENABLE is high, else for IDLE; an ENABLE drop mid-metaframe SHALL NOT truncate the metaframe.
REQ-018 SHALL register all of TX_DATA, TX_HEADER, TX_PASSTHROUGH and METAFRAME_START, with 1-cycle latency from state/input to output.
REQ-019 SHALL emit in SYNC the word 64'h78F6_78F6_78F6_78F6 with header 10, and assert METAFRAME_START.
REQ-020 SHALL emit in SCRAM the word {6'b001010, SCRAM_STATE} with header 10.
REQ-021 SHALL emit in SKIP the word 64'h1E1E_1E1E_1E1E_1E1E with header 10.
REQ-022 SHALL emit in DIAG the word {6'b011001, 24'h0, LANE_STATUS, DIAG_CRC32} with header 10.
REQ-023 SHALL drive DATA_READY combinationally high exactly when the state is PAYLOAD.
REQ-024 SHALL emit DATA_IN with header 01 on a PAYLOAD cycle with DATA_VALID high.
REQ-025 SHALL emit the Skip word with header 10 on a PAYLOAD cycle with DATA_VALID low; the payload slot counter SHALL advance either way.
REQ-026 SHALL use a 16-bit payload counter that loads 0 on entry to PAYLOAD and exits on count METAFRAME_LEN-5; it SHALL NOT wrap.
REQ-027 SHALL, in IDLE, output TX_DATA = Skip word, TX_HEADER = 10, TX_PASSTHROUGH = 1; TX_PASSTHROUGH SHALL be 0 in all other states.
REQ-028 SHALL ignore DATA_VALID outside PAYLOAD; no word is consumed.

Reset
REQ-029 SHALL, while SYSTEM_RESET_N is low, force state IDLE, counter 0, TX_DATA = Skip word, TX_HEADER = 10, TX_PASSTHROUGH = 1, METAFRAME_START = 0, DATA_READY = 0.
REQ-030 SHALL, on reset assertion mid-metaframe, abandon the metaframe immediately without emitting DIAG.
REQ-031 SHALL take its first transition out of IDLE no earlier than the first rising edge after SYSTEM_RESET_N rises.

Structure
REQ-032 SHALL place the following in shared package interlaken_pkg: SYNC_WORD, SKIP_WORD, SCRAM_TAG (6'b001010), DIAG_TAG (6'b011001), HDR_DATA (01), HDR_CTRL (10), and the state encoding.
REQ-033 SHALL be a single module with no sub-module; CRC32 and scrambler logic remain external.

Verification
REQ-034 SHALL cover: METAFRAME_LEN=8, ENABLE=1, DATA_VALID=1 with DATA_IN counting 1..n -> output repeats Sync, ScramState, Skip, 1, 2, 3, 4, Diag, Sync…; METAFRAME_START every 8 cycles.
REQ-035 SHALL cover: METAFRAME_LEN=8, DATA_VALID low on the 2nd payload cycle -> payload region reads D1, Skip(hdr 10), D2, D3; DIAG is still at slot 8.
REQ-036 SHALL cover: ENABLE dropped on the 1st payload cycle -> remaining 3 payload words and Diag are emitted, then IDLE output with TX_PASSTHROUGH=1.
REQ-037 SHALL cover: SYSTEM_RESET_N pulsed low in PAYLOAD -> outputs immediately at reset values, no Diag emitted, and Sync again 2 cycles after release with ENABLE=1.
REQ-038 SHALL cover: SCRAM_STATE=58'h2AB_CDEF_0123_4567, LANE_STATUS=2'b11, DIAG_CRC32=32'hDEADBEEF -> TX_DATA=64'h2AB_CDEF_0123_4567 | (6'b001010<<58) and 64'h6400_0003_DEAD_BEEF.
